vga_color_pipe: RTL and testbench

//  Parametrised pixel colouriser for the VGA text/glyph path. Maps the per-pixel glyph bit
//  (bit_let) to a foreground colour, picked by a one-hot switch from a writable palette,
//  or to a background colour. Adds frame-based blink and a fixed 2-cycle registered

---
 rtl/vga_color_pipe_if.sv | 31 +++
 rtl/vga_color_pipe.sv | 92 +++++++++
 tb/tb_vga_color_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/vga_color_pipe_if.sv
// rtl/vga_color_pipe_if.sv - pixel, control and palette-write bundle for the VGA colouriser
interface vga_color_pipe_if #(
    parameter int RGB_W   = 3,
    parameter int NUM_SEL = 8
);
    localparam int AW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;

    logic [NUM_SEL-1:0] switch;
    logic               bit_let;
    logic               video_on;
    logic               frame_tick;
    logic               blink_en;
    logic [RGB_W-1:0]   bg_color;
    logic               pal_we;
    logic [AW-1:0]      pal_addr;
    logic [RGB_W-1:0]   pal_data;
    logic [RGB_W-1:0]   rgb;
    logic               video_on_out;

    modport master (
        output switch, bit_let, video_on, frame_tick, blink_en, bg_color,
               pal_we, pal_addr, pal_data,
        input  rgb, video_on_out
    );

    modport slave (
        input  switch, bit_let, video_on, frame_tick, blink_en, bg_color,
               pal_we, pal_addr, pal_data,
        output rgb, video_on_out
    );
endinterface

// File: rtl/vga_color_pipe.sv
// rtl/vga_color_pipe.sv - glyph-bit colouriser with writable palette, frame blink, 2-stage pipe
module vga_color_pipe #(
    parameter int RGB_W        = 3,
    parameter int NUM_SEL      = 8,
    parameter int BLINK_FRAMES = 30
) (
    input logic            clk,
    input logic            reset_n,
    vga_color_pipe_if.slave px
);
    localparam int AW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [AW-1:0]    sel;
    logic [AW-1:0]    sw_idx;
    logic             sw_onehot;
    logic [RGB_W-1:0] palette [NUM_SEL];
    logic [RGB_W-1:0] fg_color;
    logic [CW-1:0]    frame_cnt;
    logic             blink_phase;
    logic             fg_off;
    logic [RGB_W-1:0] c1;
    logic             v1;

    // Zero or multi-hot switch patterns leave sel untouched so no glitch colour appears.
    always_comb begin
        sw_onehot = (px.switch != '0) &&
                    ((px.switch & (px.switch - {{(NUM_SEL-1){1'b0}}, 1'b1})) == '0);
        sw_idx = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (px.switch[i]) sw_idx = AW'(i);
        end
    end

    always_comb begin
        fg_color = '0;
        for (int i = 0; i < NUM_SEL; i++) begin
            if (sel == AW'(i)) fg_color = palette[i];
        end
    end

    assign fg_off = px.blink_en & blink_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel <= '0;
        end else if (sw_onehot) begin
            sel <= sw_idx;
        end
    end

    // Per-entry compare means out-of-range addresses simply match nothing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SEL; i++) begin
                palette[i] <= RGB_W'(i + 1);
            end
        end else if (px.pal_we) begin
            for (int i = 0; i < NUM_SEL; i++) begin
                if (px.pal_addr == AW'(i)) palette[i] <= px.pal_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (px.frame_tick) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c1              <= '0;
            v1              <= 1'b0;
            px.rgb          <= '0;
            px.video_on_out <= 1'b0;
        end else begin
            c1              <= (px.bit_let & ~fg_off) ? fg_color : px.bg_color;
            v1              <= px.video_on;
            px.rgb          <= v1 ? c1 : '0;
            px.video_on_out <= v1;
        end
    end
endmodule

// File: tb/tb_vga_color_pipe.sv
// tb/tb_vga_color_pipe.sv - randomized and directed checks of vga_color_pipe against a pixel model
module tb_vga_color_pipe;
    localparam int RGB_W = 3;
    localparam int NS    = 6;
    localparam int BF    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    vga_color_pipe_if #(.RGB_W(RGB_W), .NUM_SEL(NS)) bus ();

    vga_color_pipe #(.RGB_W(RGB_W), .NUM_SEL(NS), .BLINK_FRAMES(BF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .px      (bus)
    );

    always #5 clk = ~clk;

    int         pal_m [NS];
    int         sel_m;
    int         ticks_m;
    logic [3:0] q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) pal_m[i] = (i + 1) % (1 << RGB_W);
        sel_m   = 0;
        ticks_m = 0;
        q.delete();
        q.push_back(4'h0);
    endtask

    task automatic idle_inputs();
        bus.switch = '0; bus.bit_let = 1'b0; bus.video_on = 1'b0; bus.frame_tick = 1'b0;
        bus.blink_en = 1'b0; bus.bg_color = '0; bus.pal_we = 1'b0; bus.pal_addr = '0;
        bus.pal_data = '0;
    endtask

    // One pixel clock: the model decides what this sampled pixel must look like,
    // then applies the register updates the edge makes.
    task automatic step();
        logic [3:0] e;
        int         col;
        logic [2:0] c3;
        bit         fg_on;
        @(posedge clk);
        fg_on = !(bus.blink_en && ((ticks_m / BF) % 2 == 1));
        col = (bus.bit_let && fg_on) ? pal_m[sel_m] : int'(bus.bg_color);
        c3 = col[2:0];
        q.push_back({bus.video_on, bus.video_on ? c3 : 3'b000});
        if ($countones(bus.switch) == 1)
            for (int i = 0; i < NS; i++) if (bus.switch[i]) sel_m = i;
        if (bus.pal_we && int'(bus.pal_addr) < NS) pal_m[bus.pal_addr] = int'(bus.pal_data);
        if (bus.frame_tick) ticks_m++;
        e = q.pop_front();
        #1;
        check("rgb", 32'(bus.rgb), 32'(e[2:0]));
        check("video_on_out", 32'(bus.video_on_out), 32'(e[3]));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        check("reset_rgb", 32'(bus.rgb), 32'h0);
        check("reset_vout", 32'(bus.video_on_out), 32'h0);

        // Latency: pixel sampled at one edge shows on rgb after the next edge.
        bus.switch = 6'h04; step();
        bus.bit_let = 1'b1; bus.video_on = 1'b1; step();
        check("t1_not_cycle1", 32'(bus.rgb), 32'h0);
        check("t1_vout_cycle1", 32'(bus.video_on_out), 32'h0);
        step();
        check("t1_rgb_cycle2", 32'(bus.rgb), 32'h3);
        check("t1_vout_cycle2", 32'(bus.video_on_out), 32'h1);

        bus.switch = 6'h10; step();
        bus.switch = 6'h11; step();
        bus.switch = 6'h00; step(); step(); step();
        check("t2_sel_held", 32'(bus.rgb), 32'h5);

        bus.bit_let = 1'b0; bus.bg_color = 3'b010; step(); step();
        check("t3_bg", 32'(bus.rgb), 32'h2);
        bus.video_on = 1'b0; step(); step();
        check("t3_blank", 32'(bus.rgb), 32'h0);

        bus.video_on = 1'b1; bus.bit_let = 1'b1; bus.switch = 6'h04; step(); step();
        bus.pal_we = 1'b1; bus.pal_addr = 3'd2; bus.pal_data = 3'b110; step();
        bus.pal_we = 1'b0; step();
        check("t4_old_value", 32'(bus.rgb), 32'h3);
        step();
        check("t4_new_value", 32'(bus.rgb), 32'h6);
        bus.pal_we = 1'b1; bus.pal_addr = 3'd6; bus.pal_data = 3'b001; step();
        bus.pal_addr = 3'd7; step();
        bus.pal_we = 1'b0; step(); step();
        check("t4_out_of_range", 32'(bus.rgb), 32'h6);

        bus.bg_color = '0; bus.blink_en = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            bus.frame_tick = 1'b1; step();
            bus.frame_tick = 1'b0; step(); step();
            check("t5_blink", 32'(bus.rgb), ((f / 2) % 2 == 0) ? 32'h6 : 32'h0);
        end
        bus.blink_en = 1'b0;
        for (int f = 0; f < 4; f++) begin
            bus.frame_tick = 1'b1; step();
            bus.frame_tick = 1'b0; step(); step();
            check("t5_blink_off", 32'(bus.rgb), 32'h6);
        end

        // Asynchronous reset away from any clock edge.
        #3 reset_n = 1'b0;
        #1;
        check("t6_async_rgb", 32'(bus.rgb), 32'h0);
        check("t6_async_vout", 32'(bus.video_on_out), 32'h0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        bus.switch = 6'h04; step();
        bus.bit_let = 1'b1; bus.video_on = 1'b1; step(); step();
        check("t6_palette_default", 32'(bus.rgb), 32'h3);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 7) bus.switch = 6'(1 << $urandom_range(0, NS - 1));
            else bus.switch = 6'($urandom);
            bus.bit_let    = 1'($urandom);
            bus.video_on   = ($urandom_range(0, 9) != 0);
            bus.frame_tick = ($urandom_range(0, 7) == 0);
            if (n % 200 == 0) bus.blink_en = 1'($urandom);
            bus.bg_color   = 3'($urandom);
            bus.pal_we     = ($urandom_range(0, 5) == 0);
            bus.pal_addr   = 3'($urandom_range(0, 7));
            bus.pal_data   = 3'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
